rgb_window_filter: RTL and testbench

- Parametrised 3x3 neighbourhood filter for packed RGB pixels.
- Consumes one 9-pixel window per accepted beat. Produces one filtered centre pixel plus the untouched centre pixel.
- Supports eight runtime modes: channel isolation, grayscale, Gaussian blur, sharpen and Laplacian edge.
- Sits between the line-buffer/window generator and the VGA output stage. Valid/ready handshake with backpressure.

---
 rtl/rgb_window_filter.sv | 154 +++++++++++++++
 tb/tb_rgb_window_filter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_window_filter.sv
`default_nettype none
// ============================================================================
// Module   : rgb_window_filter
// Brief    : 3-stage 3x3 neighbourhood filter for packed {R,G,B} pixels with
//            runtime-selectable mode and valid/ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_window_filter #(
    parameter int CH_BITS  = 4,
    parameter int ABS_EDGE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sof,
    input  logic [2:0]              mode_in,
    input  logic [27*CH_BITS-1:0]   color_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3*CH_BITS-1:0]    filter_rgb_out,
    output logic [3*CH_BITS-1:0]    original_out,
    output logic [2:0]              active_mode
);

    localparam int c_pw = 3 * CH_BITS;
    // Signed working width: covers 8C - 8 neighbours and the Gaussian 16x sum.
    localparam int c_rw = CH_BITS + 6;

    localparam logic [2:0] c_mode_pass  = 3'd0;
    localparam logic [2:0] c_mode_red   = 3'd1;
    localparam logic [2:0] c_mode_green = 3'd2;
    localparam logic [2:0] c_mode_blue  = 3'd3;
    localparam logic [2:0] c_mode_gray  = 3'd4;
    localparam logic [2:0] c_mode_gauss = 3'd5;
    localparam logic [2:0] c_mode_sharp = 3'd6;
    localparam logic [2:0] c_mode_edge  = 3'd7;

    localparam logic signed [c_rw-1:0] c_ch_max = {{(c_rw-CH_BITS){1'b0}}, {CH_BITS{1'b1}}};

    logic                   w_advance;
    logic [2:0]             w_beat_mode;
    logic [c_pw-1:0]        w_s1_centre;
    logic [CH_BITS+1:0]     w_gray_sum;
    logic [3*c_rw-1:0]      w_s2_res;
    logic [c_pw-1:0]        w_s3_filt;

    logic                   r_s1_valid;
    logic [2:0]             r_s1_mode;
    logic [9*c_pw-1:0]      r_s1_win;
    logic                   r_s2_valid;
    logic [3*c_rw-1:0]      r_s2_res;
    logic [c_pw-1:0]        r_s2_orig;
    logic                   r_s3_valid;
    logic [c_pw-1:0]        r_s3_filt;
    logic [c_pw-1:0]        r_s3_orig;
    logic [2:0]             r_active_mode;

    // The whole pipeline moves in lock-step; any output stall freezes every stage.
    assign w_advance   = !r_s3_valid || out_ready;
    assign in_ready    = w_advance;
    assign w_beat_mode = sof ? mode_in : r_active_mode;

    assign w_s1_centre = r_s1_win[9*c_pw-1 -: c_pw];
    assign w_gray_sum  = {2'b00, w_s1_centre[c_pw-1 -: CH_BITS]}
                       + {1'b0, w_s1_centre[2*CH_BITS-1 -: CH_BITS], 1'b0}
                       + {2'b00, w_s1_centre[CH_BITS-1:0]};

    // Channel index: 2 = R (MSBs), 1 = G, 0 = B.
    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic signed [c_rw-1:0] w_px [9];
        logic signed [c_rw-1:0] w_sum4;
        logic signed [c_rw-1:0] w_diag;
        logic signed [c_rw-1:0] w_edge;
        logic signed [c_rw-1:0] w_res;
        logic signed [c_rw-1:0] w_s2_v;
        logic [CH_BITS-1:0]     w_sat;

        // Window order from pixel 0: centre, left, right, up, down, UL, UR, DL, DR.
        for (genvar k = 0; k < 9; k++) begin : g_px
            assign w_px[k] = $signed({{(c_rw-CH_BITS){1'b0}},
                                      r_s1_win[(8-k)*c_pw + ch*CH_BITS +: CH_BITS]});
        end

        assign w_sum4 = w_px[1] + w_px[2] + w_px[3] + w_px[4];
        assign w_diag = w_px[5] + w_px[6] + w_px[7] + w_px[8];
        assign w_edge = (w_px[0] <<< 3) - w_sum4 - w_diag;

        always_comb begin
            w_res = w_px[0];
            case (r_s1_mode)
                c_mode_pass:  w_res = w_px[0];
                c_mode_red:   if (ch != 2) w_res = '0;
                c_mode_green: if (ch != 1) w_res = '0;
                c_mode_blue:  if (ch != 0) w_res = '0;
                c_mode_gray:  w_res = $signed({{(c_rw-CH_BITS-2){1'b0}}, w_gray_sum}) >>> 2;
                c_mode_gauss: w_res = ((w_px[0] <<< 2) + (w_sum4 <<< 1) + w_diag) >>> 4;
                c_mode_sharp: w_res = (w_px[0] <<< 2) + w_px[0] - w_sum4;
                c_mode_edge:  w_res = ((ABS_EDGE != 0) && w_edge[c_rw-1]) ? -w_edge : w_edge;
                default:      w_res = w_px[0];
            endcase
        end

        assign w_s2_res[ch*c_rw +: c_rw] = w_res;
        assign w_s2_v = $signed(r_s2_res[ch*c_rw +: c_rw]);

        always_comb begin
            if (w_s2_v[c_rw-1]) begin
                w_sat = '0;
            end else if (w_s2_v > c_ch_max) begin
                w_sat = '1;
            end else begin
                w_sat = w_s2_v[CH_BITS-1:0];
            end
        end

        assign w_s3_filt[ch*CH_BITS +: CH_BITS] = w_sat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_mode     <= '0;
            r_s1_win      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_res      <= '0;
            r_s2_orig     <= '0;
            r_s3_valid    <= 1'b0;
            r_s3_filt     <= '0;
            r_s3_orig     <= '0;
            r_active_mode <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_mode  <= w_beat_mode;
            r_s1_win   <= color_data;
            if (in_valid && sof) begin
                r_active_mode <= mode_in;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_res   <= w_s2_res;
            r_s2_orig  <= w_s1_centre;
            r_s3_valid <= r_s2_valid;
            r_s3_filt  <= w_s3_filt;
            r_s3_orig  <= r_s2_orig;
        end
    end

    assign out_valid      = r_s3_valid;
    assign filter_rgb_out = r_s3_filt;
    assign original_out   = r_s3_orig;
    assign active_mode    = r_active_mode;

endmodule
`default_nettype wire

// File: tb/tb_rgb_window_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_window_filter
// Brief    : Scoreboard bench for rgb_window_filter (ABS_EDGE = 0 and 1 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_window_filter;

    localparam int CB = 4;
    localparam int PW = 3 * CB;

    typedef logic [PW-1:0] win_t [9];
    typedef struct {
        logic [PW-1:0] f0;
        logic [PW-1:0] f1;
        logic [PW-1:0] orig;
        int            cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            sof = 1'b0;
    logic            out_ready = 1'b1;
    logic [2:0]      mode_in = '0;
    logic [9*PW-1:0] color_data = '0;
    logic            in_ready0, in_ready1, ov0, ov1;
    logic [PW-1:0]   filt0, filt1, orig0, orig1;
    logic [2:0]      am0, am1;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         stall_cnt = 0;
    bit         rand_rdy = 1'b0;
    bit         chk_lat = 1'b0;
    logic [2:0] model_mode = '0;
    exp_t       sb[$];
    win_t       zw = '{default: '0};

    rgb_window_filter #(.CH_BITS(CB), .ABS_EDGE(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .sof(sof), .mode_in(mode_in), .color_data(color_data),
        .out_valid(ov0), .out_ready(out_ready), .filter_rgb_out(filt0),
        .original_out(orig0), .active_mode(am0)
    );

    rgb_window_filter #(.CH_BITS(CB), .ABS_EDGE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .sof(sof), .mode_in(mode_in), .color_data(color_data),
        .out_valid(ov1), .out_ready(out_ready), .filter_rgb_out(filt1),
        .original_out(orig1), .active_mode(am1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: channel arithmetic straight from the mode definitions, on ints.
    function automatic logic [PW-1:0] ref_filter(input win_t w, input logic [2:0] mode, input bit abs_edge);
        int v [9][3];
        int r, y, n4, d4;
        logic [PW-1:0] res;
        res = '0;
        for (int k = 0; k < 9; k++)
            for (int c = 0; c < 3; c++)
                v[k][c] = (int'(w[k]) >> (CB * (2 - c))) % (1 << CB);
        y = (v[0][0] + 2 * v[0][1] + v[0][2]) / 4;
        for (int c = 0; c < 3; c++) begin
            n4 = v[1][c] + v[2][c] + v[3][c] + v[4][c];
            d4 = v[5][c] + v[6][c] + v[7][c] + v[8][c];
            case (mode)
                3'd0: r = v[0][c];
                3'd1: r = (c == 0) ? v[0][c] : 0;
                3'd2: r = (c == 1) ? v[0][c] : 0;
                3'd3: r = (c == 2) ? v[0][c] : 0;
                3'd4: r = y;
                3'd5: r = (4 * v[0][c] + 2 * n4 + d4) / 16;
                3'd6: r = 5 * v[0][c] - n4;
                default: begin
                    r = 8 * v[0][c] - n4 - d4;
                    if (abs_edge && r < 0) r = -r;
                end
            endcase
            if (r < 0) r = 0;
            if (r > (1 << CB) - 1) r = (1 << CB) - 1;
            res = (res << CB) | PW'(r);
        end
        return res;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int k = 0; k < 9; k++) begin
            case ($urandom_range(3))
                0: w[k] = '0;
                1: w[k] = '1;
                default: w[k] = PW'($urandom);
            endcase
        end
        return w;
    endfunction

    task automatic step(input bit v, input win_t w, input bit s, input logic [2:0] m,
                        input bit use_exp, input logic [PW-1:0] e0, input logic [PW-1:0] e1,
                        output bit acc);
        exp_t ent;
        @(negedge clk);
        chk("active_mode", 32'(am0), 32'(model_mode));
        chk("active_mode_abs", 32'(am1), 32'(model_mode));
        in_valid = v;
        sof      = s;
        mode_in  = m;
        for (int k = 0; k < 9; k++) color_data[(8-k)*PW +: PW] = w[k];
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else begin
            out_ready = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
        end
        #1;
        acc = v && in_ready0;
        if (acc) begin
            if (s) model_mode = m;
            ent.f0   = use_exp ? e0 : ref_filter(w, model_mode, 1'b0);
            ent.f1   = use_exp ? e1 : ref_filter(w, model_mode, 1'b1);
            ent.orig = w[0];
            ent.cyc  = cyc;
            sb.push_back(ent);
        end
    endtask

    task automatic send(input win_t w, input bit s, input logic [2:0] m,
                        input bit use_exp, input logic [PW-1:0] e0, input logic [PW-1:0] e1);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            step(1'b1, w, s, m, use_exp, e0, e1, acc);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: not accepted in %0d cycles, required acceptance", n);
        end
    endtask

    task automatic idle();
        bit acc;
        step(1'b0, zw, 1'b0, 3'd0, 1'b0, '0, '0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_rdy = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            idle();
            n++;
        end
        repeat (4) idle();
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        sof       = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        model_mode = '0;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out_valid_abs", 32'(ov1), 32'd0);
        chk("rst_filter", 32'(filt0), 32'd0);
        chk("rst_filter_abs", 32'(filt1), 32'd0);
        chk("rst_original", 32'(orig0), 32'd0);
        chk("rst_original_abs", 32'(orig1), 32'd0);
        chk("rst_active_mode", 32'(am0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        reset = 1'b0;
    endtask

    // Monitor: pops on every transfer, and re-checks the held head while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                chk("in_ready", 32'(in_ready0), 32'(!ov0 || out_ready));
                chk("in_ready_abs", 32'(in_ready1), 32'(!ov1 || out_ready));
                if (ov0) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got %0h with no beat outstanding, required none", filt0);
                    end else begin
                        e = sb[0];
                        chk("filter", 32'(filt0), 32'(e.f0));
                        chk("filter_abs", 32'(filt1), 32'(e.f1));
                        chk("original", 32'(orig0), 32'(e.orig));
                        if (out_ready) begin
                            if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        win_t w;
        logic [PW-1:0] e_tab [8] = '{12'hABC, 12'hA00, 12'h0B0, 12'h00C,
                                     12'hBBB, 12'hABC, 12'hABC, 12'h000};
        do_reset(2);

        // Uniform 0xABC window through every mode, back to back.
        chk_lat = 1'b1;
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 9; k++) w[k] = 12'hABC;
            send(w, 1'b1, 3'(m), 1'b1, e_tab[m], e_tab[m]);
        end
        drain();
        chk_lat = 1'b0;

        // Saturation and Gaussian corner cases.
        w = zw; w[0] = 12'hF00;
        send(w, 1'b1, 3'd6, 1'b1, 12'hF00, 12'hF00);
        send(w, 1'b1, 3'd7, 1'b1, 12'hF00, 12'hF00);
        w = '{default: 12'hFFF}; w[0] = 12'h000;
        send(w, 1'b1, 3'd7, 1'b1, 12'h000, 12'hFFF);
        w = zw; w[0] = 12'hFFF;
        send(w, 1'b1, 3'd5, 1'b1, 12'h333, 12'h333);
        w = zw; w[5] = 12'hFFF;
        send(w, 1'b1, 3'd5, 1'b1, 12'h000, 12'h000);
        drain();

        // mode_in ignored on non-sof beats; in-flight beats keep their mode.
        send(rand_win(), 1'b1, 3'd2, 1'b0, '0, '0);
        repeat (3) send(rand_win(), 1'b0, 3'd5, 1'b0, '0, '0);
        send(rand_win(), 1'b1, 3'd4, 1'b0, '0, '0);
        repeat (3) send(rand_win(), 1'b0, 3'd1, 1'b0, '0, '0);
        drain();

        // Ten-beat stream with a four-cycle output stall in the middle.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) stall_cnt = 4;
            send(rand_win(), i == 0, 3'd6, 1'b0, '0, '0);
        end
        drain();

        // Reset with three beats in flight; none may reappear.
        send(rand_win(), 1'b1, 3'd3, 1'b0, '0, '0);
        send(rand_win(), 1'b0, 3'd0, 1'b0, '0, '0);
        send(rand_win(), 1'b0, 3'd0, 1'b0, '0, '0);
        do_reset(1);
        repeat (4) send(rand_win(), 1'b0, 3'd0, 1'b0, '0, '0);
        drain();

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0) idle();
            else send(rand_win(), $urandom_range(7) == 0, 3'($urandom_range(7)), 1'b0, '0, '0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
